pc_fetch_unit: RTL and testbench

- Sequential consumer of the +2 next-address path: owns the 16-bit program counter and issues word fetches to instruction memory.
- Advances PC by INC_STEP per accepted instruction, and honours branch/jump redirects and decode back-pressure.
- Sits between instruction memory and the decode stage; one outstanding fetch at a time.

---
 rtl/pc_fetch_unit_pkg.sv | 21 ++
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and state encoding for the program-counter fetch unit.
//   PFU_ADDR_W    : PC / fetch address width
//   PFU_INSTR_W   : instruction word width
//   PFU_RESET_PC  : PC loaded on reset
//   PFU_INC_STEP  : byte increment per accepted instruction
//   fetch_state_t : FSM encoding (REQ, WAIT, HOLD, DROP)
package pc_fetch_unit_pkg;

   localparam int          PFU_ADDR_W   = 16;
   localparam int          PFU_INSTR_W  = 16;
   localparam logic [15:0] PFU_RESET_PC = 16'h0000;
   localparam int          PFU_INC_STEP = 2;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: owns the PC, issues one word fetch at a time to
// instruction memory, buffers the returned instruction for decode and honours
// branch/jump redirects.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/addr/ready       fetch request handshake (addr = pc)
//   imem_rsp_valid/data             fetch response
//   instr_valid/out/pc              buffered instruction to decode
//   decode_ready                    decode consumes the buffered instruction
//   redirect_valid/target           taken branch/jump, target forced to halfword
//   pc_out                          current PC
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request valid at pc, waiting for memory to accept
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction buffered, waiting for decode to take it
// DROP  | redirected with a fetch in flight; swallow that stale response
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = PFU_ADDR_W,
   parameter int                INSTR_W  = PFU_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PFU_RESET_PC),
   parameter int                INC_STEP = PFU_INC_STEP
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               decode_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic [ADDR_W-1:0]  pc_out
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0] instr_out_q, instr_out_d;
   logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_PC;
         instr_valid_q <= 1'b0;
         instr_out_q   <= '0;
         instr_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
         instr_out_q   <= instr_out_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_valid_d = instr_valid_q;
      instr_out_d   = instr_out_q;
      instr_pc_d    = instr_pc_q;

      if (redirect_valid) begin
         pc_d          = {redirect_target[ADDR_W-1:1], 1'b0};
         instr_valid_d = 1'b0;
         case (state_q)
            // An accepted request still owes us a response: go swallow it.
            ST_REQ:  state_d = imem_req_ready ? ST_DROP : ST_REQ;
            // If the owed response lands this very cycle it is the one being
            // discarded, so nothing is left in flight.
            ST_WAIT,
            ST_DROP: state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
            default: state_d = ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  instr_out_d   = imem_rsp_data;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + ADDR_W'(INC_STEP);
                  state_d       = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (decode_ready) begin
                  instr_valid_d = 1'b0;
                  state_d       = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem_rsp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   // Held low while rst is asserted so no request escapes during reset.
   assign imem_req_valid = (state_q == ST_REQ) && !rst;
   assign imem_req_addr  = pc_q;
   assign instr_valid    = instr_valid_q;
   assign instr_out      = instr_out_q;
   assign instr_pc       = instr_pc_q;
   assign pc_out         = pc_q;

   // A response is only legal while one is owed; the cycle right after reset
   // may still see the response of an abandoned fetch.
   a_rsp_only_when_owed: assert property (@(posedge clk) disable iff (rst)
      (imem_rsp_valid && !$past(rst)) |-> (state_q == ST_WAIT || state_q == ST_DROP));

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic [15:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [15:0] imem_rsp_data = '0;
   logic        instr_valid;
   logic [15:0] instr_out, instr_pc, pc_out;
   logic        decode_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_target = '0;

   // second instance with a reset PC at the top of the address space
   logic        b_req_valid;
   logic [15:0] b_req_addr;
   logic        b_req_ready = 1'b0;
   logic        b_rsp_valid = 1'b0;
   logic [15:0] b_rsp_data = '0;
   logic        b_instr_valid;
   logic [15:0] b_instr_out, b_instr_pc, b_pc_out;
   logic        b_decode_ready = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   pc_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
      .decode_ready(decode_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .pc_out(pc_out)
   );

   pc_fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
      .clk(clk), .rst(rst),
      .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
      .imem_req_ready(b_req_ready),
      .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
      .instr_valid(b_instr_valid), .instr_out(b_instr_out), .instr_pc(b_instr_pc),
      .decode_ready(b_decode_ready),
      .redirect_valid(1'b0), .redirect_target(16'h0000),
      .pc_out(b_pc_out)
   );

   always #5 clk = ~clk;

   // memory model: one outstanding fetch, response after lat_min..lat_max cycles
   logic [15:0] mem [0:255];
   logic        outst = 1'b0;
   int          cnt = 0;
   logic [15:0] outst_addr = '0;
   int          ready_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   logic        acc = 1'b0;
   logic [15:0] acc_addr = '0;
   logic [15:0] req_log[$];

   // reference model: PC, in-flight flag (+stale), single buffered instruction
   logic [15:0] m_pc;
   logic        m_outst, m_stale, m_hold;
   logic [15:0] m_hdata, m_hpc;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; decode_ready = 1'b0;
      redirect_valid = 1'b0; b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_decode_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      outst = 1'b0;
      #1;
   endtask

   task automatic mem_drive(input logic dec, input logic redir, input logic [15:0] tgt);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (outst) begin
         cnt--;
         if (cnt <= 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[outst_addr[8:1]];
         end
      end
      imem_req_ready  = (int'($urandom_range(99)) < ready_pct);
      decode_ready    = dec;
      redirect_valid  = redir;
      redirect_target = tgt;
      #1;
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
   endtask

   task automatic mem_clock();
      @(posedge clk);
      if (imem_rsp_valid) outst = 1'b0;
      if (acc) begin
         outst      = 1'b1;
         cnt        = lat_min + int'($urandom_range(lat_max - lat_min));
         outst_addr = acc_addr;
         req_log.push_back(acc_addr);
      end
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   function automatic void model_step();
      logic accepted;
      accepted = !m_outst && !m_hold && imem_req_ready;
      if (redirect_valid) begin
         m_pc   = {redirect_target[15:1], 1'b0};
         m_hold = 1'b0;
         if (accepted) begin
            m_outst = 1'b1; m_stale = 1'b1;
         end else if (m_outst) begin
            if (imem_rsp_valid) m_outst = 1'b0;
            else                m_stale = 1'b1;
         end
      end else if (accepted) begin
         m_outst = 1'b1; m_stale = 1'b0;
      end else if (m_outst && imem_rsp_valid) begin
         m_outst = 1'b0;
         if (!m_stale) begin
            m_hold  = 1'b1;
            m_hdata = imem_rsp_data;
            m_hpc   = m_pc;
            m_pc    = m_pc + 16'd2;
         end
      end else if (m_hold && decode_ready) begin
         m_hold = 1'b0;
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
      tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
      tests_run++; if (instr_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr_out got %h want 0000", instr_out); end
      tests_run++; if (instr_pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr_pc got %h want 0000", instr_pc); end
      tests_run++; if (pc_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc_out got %h want 0000", pc_out); end
      rst = 1'b0;
      #1;
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin tests_failed++; $display("FAIL post_reset_req got v=%b a=%h want v=1 a=0000", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_sequence();
      logic [15:0] exp_d[3];
      logic [15:0] exp_a[3];
      logic [15:0] got_d[$];
      logic [15:0] got_p[$];
      exp_d = '{16'h1111, 16'h2222, 16'h3333};
      exp_a = '{16'h0000, 16'h0002, 16'h0004};
      do_reset();
      ready_pct = 100; lat_min = 1; lat_max = 1;
      req_log.delete();
      for (int c = 0; c < 30; c++) begin
         if (instr_valid) begin got_d.push_back(instr_out); got_p.push_back(instr_pc); end
         if (got_d.size() == 3) break;
         mem_drive(1'b1, 1'b0, 16'h0);
         mem_clock();
      end
      tests_run++; if (got_d.size() != 3) begin tests_failed++; $display("FAIL seq_count got %0d want 3 (timeout)", got_d.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < got_d.size()) begin
            tests_run++; if (got_d[i] !== exp_d[i] || got_p[i] !== exp_a[i]) begin tests_failed++; $display("FAIL seq_instr[%0d] got (%h,%h) want (%h,%h)", i, got_d[i], got_p[i], exp_d[i], exp_a[i]); end
         end
         if (i < req_log.size()) begin
            tests_run++; if (req_log[i] !== exp_a[i]) begin tests_failed++; $display("FAIL seq_req_addr[%0d] got %h want %h", i, req_log[i], exp_a[i]); end
         end
      end
   endtask

   task automatic test_stall();
      int n;
      do_reset();
      ready_pct = 100; lat_min = 1; lat_max = 1;
      n = 0;
      while (!instr_valid && n < 20) begin mem_drive(1'b0, 1'b0, 16'h0); mem_clock(); n++; end
      tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_first_instr timeout, instr_valid got %b want 1", instr_valid); end
      for (int c = 0; c < 5; c++) begin
         mem_drive(1'b0, 1'b0, 16'h0);
         tests_run++; if (instr_valid !== 1'b1 || instr_out !== 16'h1111) begin tests_failed++; $display("FAIL stall_hold[%0d] got v=%b d=%h want v=1 d=1111", c, instr_valid, instr_out); end
         tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_no_req[%0d] got %b want 0", c, imem_req_valid); end
         tests_run++; if (pc_out !== 16'h0002) begin tests_failed++; $display("FAIL stall_pc[%0d] got %h want 0002", c, pc_out); end
         mem_clock();
      end
      mem_drive(1'b1, 1'b0, 16'h0);
      imem_req_ready = 1'b0;
      acc = 1'b0;
      mem_clock();
      tests_run++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0002) begin tests_failed++; $display("FAIL stall_release got v=%b rv=%b a=%h want v=0 rv=1 a=0002", instr_valid, imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_redirect_hold();
      int n;
      do_reset();
      ready_pct = 100; lat_min = 1; lat_max = 1;
      n = 0;
      while (!instr_valid && n < 20) begin mem_drive(1'b0, 1'b0, 16'h0); mem_clock(); n++; end
      tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL rdh_reach_hold timeout, instr_valid got %b want 1", instr_valid); end
      // decode_ready high together with the redirect: instruction is still discarded
      mem_drive(1'b1, 1'b1, 16'h0041);
      mem_clock();
      tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rdh_valid_drop got %b want 0", instr_valid); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0040) begin tests_failed++; $display("FAIL rdh_next_req got v=%b a=%h want v=1 a=0040", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 16'h0100;
      tick();
      redirect_valid = 1'b0;
      tests_run++; if (pc_out !== 16'h0100 || imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rdw_after_redirect got pc=%h rv=%b want pc=0100 rv=0", pc_out, imem_req_valid); end
      tick();
      tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rdw_waiting_stale got rv=%b want 0", imem_req_valid); end
      imem_rsp_valid = 1'b1; imem_rsp_data = 16'hDEAD;
      tick();
      imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0000;
      tests_run++; if (instr_valid !== 1'b0 || instr_out === 16'hDEAD) begin tests_failed++; $display("FAIL rdw_stale_swallowed got v=%b d=%h want v=0 d!=dead", instr_valid, instr_out); end
      tests_run++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100) begin tests_failed++; $display("FAIL rdw_next_req got v=%b a=%h want v=1 a=0100", imem_req_valid, imem_req_addr); end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h0B0B;
      tick();
      imem_rsp_valid = 1'b0;
      tests_run++; if (instr_valid !== 1'b1 || instr_out !== 16'h0B0B || instr_pc !== 16'h0100) begin tests_failed++; $display("FAIL rdw_target_instr got v=%b d=%h p=%h want v=1 d=0b0b p=0100", instr_valid, instr_out, instr_pc); end
   endtask

   task automatic test_wrap();
      int n;
      do_reset();
      ready_pct = 100; lat_min = 1; lat_max = 1;
      mem_drive(1'b0, 1'b1, 16'hFFFF);
      imem_req_ready = 1'b0;
      acc = 1'b0;
      mem_clock();
      tests_run++; if (pc_out !== 16'hFFFE || imem_req_addr !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_align got pc=%h a=%h want fffe", pc_out, imem_req_addr); end
      n = 0;
      while (!instr_valid && n < 20) begin mem_drive(1'b0, 1'b0, 16'h0); mem_clock(); n++; end
      tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFE || pc_out !== 16'h0000) begin tests_failed++; $display("FAIL wrap_pc got v=%b ipc=%h pc=%h want v=1 ipc=fffe pc=0000", instr_valid, instr_pc, pc_out); end
      // second instance starts at FFFE straight out of reset
      do_reset();
      tests_run++; if (b_req_valid !== 1'b1 || b_req_addr !== 16'hFFFE) begin tests_failed++; $display("FAIL b_first_req got v=%b a=%h want v=1 a=fffe", b_req_valid, b_req_addr); end
      b_req_ready = 1'b1;
      tick();
      b_req_ready = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = 16'h0BEE;
      tick();
      b_rsp_valid = 1'b0; b_decode_ready = 1'b1;
      tests_run++; if (b_instr_valid !== 1'b1 || b_instr_out !== 16'h0BEE || b_instr_pc !== 16'hFFFE) begin tests_failed++; $display("FAIL b_first_instr got v=%b d=%h p=%h want v=1 d=0bee p=fffe", b_instr_valid, b_instr_out, b_instr_pc); end
      tick();
      b_decode_ready = 1'b0;
      tests_run++; if (b_req_valid !== 1'b1 || b_req_addr !== 16'h0000) begin tests_failed++; $display("FAIL b_wrap_req got v=%b a=%h want v=1 a=0000", b_req_valid, b_req_addr); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      redirect_valid = 1'b1; redirect_target = 16'h0300;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      // reset, a response and a redirect all in the same cycle: reset wins
      rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1234;
      redirect_valid = 1'b1; redirect_target = 16'h0500;
      tick();
      redirect_valid = 1'b0;
      tests_run++; if (instr_valid !== 1'b0 || pc_out !== 16'h0000 || imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wait got v=%b pc=%h rv=%b want v=0 pc=0000 rv=0", instr_valid, pc_out, imem_req_valid); end
      rst = 1'b0;
      // stray response in the first cycle after reset is ignored
      tick();
      imem_rsp_valid = 1'b0;
      tests_run++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin tests_failed++; $display("FAIL rst_first_req got v=%b rv=%b a=%h want v=0 rv=1 a=0000", instr_valid, imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_random();
      do_reset();
      ready_pct = 70; lat_min = 1; lat_max = 3;
      m_pc = 16'h0000; m_outst = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_hdata = '0; m_hpc = '0;
      for (int c = 0; c < 600; c++) begin
         tests_run++; if (instr_valid !== m_hold) begin tests_failed++; $display("FAIL rnd_instr_valid cyc %0d got %b want %b", c, instr_valid, m_hold); end
         if (m_hold) begin
            tests_run++; if (instr_out !== m_hdata || instr_pc !== m_hpc) begin tests_failed++; $display("FAIL rnd_instr cyc %0d got (%h,%h) want (%h,%h)", c, instr_out, instr_pc, m_hdata, m_hpc); end
         end
         tests_run++; if (imem_req_valid !== (!m_outst && !m_hold)) begin tests_failed++; $display("FAIL rnd_req_valid cyc %0d got %b want %b", c, imem_req_valid, !m_outst && !m_hold); end
         tests_run++; if (pc_out !== m_pc || imem_req_addr !== m_pc) begin tests_failed++; $display("FAIL rnd_pc cyc %0d got pc=%h a=%h want %h", c, pc_out, imem_req_addr, m_pc); end
         mem_drive(1'($urandom_range(1)), ($urandom_range(11) == 0), 16'($urandom));
         model_step();
         mem_clock();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
      test_reset();
      test_sequence();
      test_stall();
      test_redirect_hold();
      test_redirect_wait();
      test_wrap();
      test_reset_in_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
